cmp_sort_ctrl: RTL and testbench
================================

// Module: cmp_sort_ctrl
// PURPOSE
//  Sequencer that time-shares one magnitude comparator (sub-module mag_cmp) to sort a block of DEPTH
//  unsigned words. It takes a frame in over a valid/ready stream, bubble-sorts it in place
//  (ascending) one compare per cycle, then drains it out as a valid/ready stream tagged with last.
//  It sits between a producer and a consumer as a stand-alone sort stage.
// PARAMETERS
//  WIDTH  8  data word width, unsigned
//  DEPTH  8  words per frame; >=2; index/count width CW = $clog2(DEPTH)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      producer has in_data
//  in_ready   out  1      block accepts a word this cycle
//  in_data    in   WIDTH  input word
//  out_valid  out  1      out_data is valid
//  out_ready  in   1      consumer accepts out_data
//  out_data   out  WIDTH  sorted word
//  out_last   out  1      qualifies the final word of the frame (with out_valid)
//  busy       out  1      high in SORT and DRAIN
// BEHAVIOUR
//  - Reset (async, rst=1): state=LOAD, all counters 0, buf cleared to 0; in_ready=1, out_valid=0,
//    out_last=0, out_data=0, busy=0. Reset mid-frame discards the frame; there is no recovery.
//  - FSM: LOAD -> SORT -> DRAIN -> LOAD.
//  - LOAD: in_ready=1. Each in_valid&in_ready writes buf[wr_idx], wr_idx++. The handshake that writes
//    word DEPTH-1 moves to SORT on the next edge. in_ready=0 in all other states; in_valid ignored.
//  - SORT: pass p = 0..DEPTH-2, position j = 0..DEPTH-2-p, one compare per cycle on buf[j] vs
//    buf[j+1] through mag_cmp. If greater, swap them on the same edge. Equal or less: no swap
//    (stable; equal keys keep arrival order). j wraps to 0 and p++ at end of pass.
//    Fixed duration DEPTH*(DEPTH-1)/2 cycles (28 at DEPTH=8). After the last compare -> DRAIN.
//  - DRAIN: out_valid=1, out_data=buf[rd_idx], out_last=(rd_idx==DEPTH-1). On out_valid&out_ready,
//    rd_idx++. If out_ready=0, out_data/out_last hold stable. The handshake on the last word returns
//    to LOAD on the next edge (in_ready rises one cycle after, never in the same cycle).
//  - Latency: last input handshake at edge N; first compare in cycle N+1; first out_valid in cycle
//    N+1+28 (DEPTH=8, no early exit).
//  - Arithmetic: comparison unsigned, full WIDTH; no width extension; counters wrap only by FSM
//    control, never by overflow.
// CONFIGURATION
//  - SORT_EARLY_EXIT_EN defined: per-pass swap flag, cleared at pass start. A pass that completes
//    with zero swaps goes straight to DRAIN on the next edge. Sort duration for an already-sorted
//    frame = DEPTH-1 cycles; the output order is identical to the non-early-exit build.
//  - Not defined: SORT always takes exactly DEPTH*(DEPTH-1)/2 cycles; the swap flag is not built.
// STRUCTURE
//  - Package cmp_sort_pkg: state enum typedef {LOAD,SORT,DRAIN}, state encoding localparams, and
//    the SORT_CYCLES function DEPTH*(DEPTH-1)/2.
//  - One sub-module: mag_cmp #(WIDTH), purely combinational, outputs less/greater/equal. Exactly one
//    instance, with its inputs muxed from buf[j] and buf[j+1].
//  - Top holds the buffer register array, the index counters and the FSM.
// TESTING
//  1 Load 125,140,200,2,10,210,21,100; out_ready=1. Out: 2,10,21,100,125,140,200,210; last only on
//    210; first out_valid 28 cycles after the last load handshake.
//  2 Load 5,5,5,5,5,5,5,5. Out: eight 5s, out_last on the 8th. With SORT_EARLY_EXIT_EN, out_valid
//    7 cycles after the last load.
//  3 Load 255,254,...,248 (reverse sorted). Out: 248..255; 28-cycle sort in both builds.
//  4 Backpressure: out_ready toggles 1,0,0,1... during DRAIN -> out_data/out_last hold while
//    out_ready=0; exactly 8 handshakes; in_ready=0 until the cycle after the final handshake.
//  5 Reset mid-SORT (assert rst 10 cycles into the sort) -> out_valid=0, busy=0, in_ready=1
//    immediately; then a fresh frame 1..8 sorts correctly.
//  6 in_valid held high during SORT/DRAIN with data 0xAA -> no word accepted; the frame is
//    unchanged; the next frame loads normally.

Source files
------------

// File: rtl/cmp_sort_pkg.sv
// Shared types and helpers for the cmp_sort_ctrl sort stage.
package cmp_sort_pkg;

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_SORT  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef enum logic [1:0] {
      LOAD  = ST_LOAD,
      SORT  = ST_SORT,
      DRAIN = ST_DRAIN
   } state_t;

   // Compare count of a full bubble sort over depth words.
   function automatic int unsigned sort_cycles(input int unsigned depth);
      return depth * (depth - 1) / 2;
   endfunction

endpackage

// File: rtl/cmp_sort_ctrl_mag_cmp.sv
// Combinational unsigned magnitude comparator shared by the sort sequencer.
module mag_cmp #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             less,
   output logic             greater,
   output logic             equal
);

   always_comb begin
      less    = (a < b);
      greater = (a > b);
      equal   = (a == b);
   end

endmodule

// File: rtl/cmp_sort_ctrl.sv
// Frame sort stage: load DEPTH words, bubble-sort in place one compare per cycle, drain with last.
// Optional build macro SORT_EARLY_EXIT_EN ends the sort after the first pass with no swaps.
module cmp_sort_ctrl
   import cmp_sort_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy
);

   localparam int unsigned   CW       = $clog2(DEPTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
   localparam logic [CW-1:0] LAST_POS = CW'(DEPTH - 2);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] mem     [DEPTH];
   logic [WIDTH-1:0] mem_nxt [DEPTH];
   logic [CW-1:0]    wr_idx, wr_idx_nxt;
   logic [CW-1:0]    rd_idx, rd_idx_nxt;
   logic [CW-1:0]    pass_idx, pass_nxt;
   logic [CW-1:0]    pos, pos_nxt, pos_p1;
   logic [WIDTH-1:0] cmp_a, cmp_b;
   logic             cmp_lt, cmp_gt, cmp_eq;
   logic             swap, pass_end, last_cmp, early_done;
   logic             in_ready_nxt, out_valid_nxt, out_last_nxt, busy_nxt;
   logic [WIDTH-1:0] out_data_nxt;

   assign pos_p1 = pos + CW'(1);
   assign cmp_a  = mem[pos];
   assign cmp_b  = mem[pos_p1];

   mag_cmp #(.WIDTH(WIDTH)) u_mag_cmp (
      .a       (cmp_a),
      .b       (cmp_b),
      .less    (cmp_lt),
      .greater (cmp_gt),
      .equal   (cmp_eq)
   );

   // Swap only on a clean one-hot "greater"; equal keys keep arrival order.
   assign swap     = (state == SORT) && cmp_gt && !(cmp_lt || cmp_eq);
   assign pass_end = (pos == (LAST_POS - pass_idx));
   assign last_cmp = (pass_idx == LAST_POS) && pass_end;

`ifdef SORT_EARLY_EXIT_EN
   logic swapped, swapped_nxt;

   always_comb begin
      swapped_nxt = 1'b0;
      if (state == SORT && !pass_end)
         swapped_nxt = swapped | swap;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) swapped <= 1'b0;
      else     swapped <= swapped_nxt;
   end

   assign early_done = (state == SORT) && pass_end && !(swapped || swap);
`else
   assign early_done = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD;
      else     state <= state_nxt;
   end

   // Next state, next buffer contents and next counters.
   always_comb begin
      state_nxt  = state;
      mem_nxt    = mem;
      wr_idx_nxt = wr_idx;
      rd_idx_nxt = rd_idx;
      pass_nxt   = pass_idx;
      pos_nxt    = pos;
      case (state)
         LOAD: begin
            if (in_valid) begin
               mem_nxt[wr_idx] = in_data;
               if (wr_idx == LAST_IDX) begin
                  wr_idx_nxt = '0;
                  state_nxt  = SORT;
               end else begin
                  wr_idx_nxt = wr_idx + CW'(1);
               end
            end
         end
         SORT: begin
            if (swap) begin
               mem_nxt[pos]    = mem[pos_p1];
               mem_nxt[pos_p1] = mem[pos];
            end
            if (last_cmp || early_done) begin
               pos_nxt   = '0;
               pass_nxt  = '0;
               state_nxt = DRAIN;
            end else if (pass_end) begin
               pos_nxt  = '0;
               pass_nxt = pass_idx + CW'(1);
            end else begin
               pos_nxt = pos_p1;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (rd_idx == LAST_IDX) begin
                  rd_idx_nxt = '0;
                  state_nxt  = LOAD;
               end else begin
                  rd_idx_nxt = rd_idx + CW'(1);
               end
            end
         end
         default: state_nxt = LOAD;
      endcase
   end

   // Output values for the coming cycle, registered below.
   always_comb begin
      in_ready_nxt  = (state_nxt == LOAD);
      out_valid_nxt = (state_nxt == DRAIN);
      busy_nxt      = (state_nxt != LOAD);
      out_data_nxt  = '0;
      out_last_nxt  = 1'b0;
      if (state_nxt == DRAIN) begin
         out_data_nxt = mem_nxt[rd_idx_nxt];
         out_last_nxt = (rd_idx_nxt == LAST_IDX);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_idx    <= '0;
         rd_idx    <= '0;
         pass_idx  <= '0;
         pos       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         mem       <= mem_nxt;
         wr_idx    <= wr_idx_nxt;
         rd_idx    <= rd_idx_nxt;
         pass_idx  <= pass_nxt;
         pos       <= pos_nxt;
         in_ready  <= in_ready_nxt;
         out_valid <= out_valid_nxt;
         out_data  <= out_data_nxt;
         out_last  <= out_last_nxt;
         busy      <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Randomized self-checking bench for cmp_sort_ctrl against a behavioural sort model.
module tb_cmp_sort_ctrl;
   import cmp_sort_pkg::*;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 8;
   typedef logic [WIDTH-1:0] frame_t [DEPTH];

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   cmp_sort_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Ascending order built by repeatedly taking the earliest smallest remaining word.
   function automatic frame_t model_sort(input frame_t w);
      frame_t r;
      bit     used [DEPTH];
      for (int k = 0; k < DEPTH; k++) used[k] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         int best = -1;
         for (int k = 0; k < DEPTH; k++)
            if (!used[k] && (best < 0 || w[k] < w[best])) best = k;
         used[best] = 1'b1;
         r[i] = w[best];
      end
      return r;
   endfunction

   // Sort duration: full compare count, or with early exit the passes up to the first swap-free one.
   function automatic int exp_sort_cycles(input frame_t w);
`ifdef SORT_EARLY_EXIT_EN
      frame_t a = w;
      int total = 0;
      for (int p = 0; p < DEPTH - 1; p++) begin
         bit sw = 1'b0;
         for (int j = 0; j < DEPTH - 1 - p; j++) begin
            total++;
            if (a[j] > a[j+1]) begin
               logic [WIDTH-1:0] t = a[j];
               a[j] = a[j+1];
               a[j+1] = t;
               sw = 1'b1;
            end
         end
         if (!sw) return total;
      end
      return total;
`else
      return int'(sort_cycles(DEPTH));
`endif
   endfunction

   task automatic load_frame(input frame_t w, input bit hold_aa);
      for (int i = 0; i < DEPTH; i++) begin
         int guard = 0;
         @(negedge clk);
         while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         check("load_in_ready", 32'(in_ready), 32'd1);
         in_valid = 1'b1;
         in_data  = w[i];
         @(posedge clk);
      end
      #1;
      in_valid = hold_aa;
      in_data  = hold_aa ? 8'hAA : 8'h00;
   endtask

   task automatic wait_sort(input frame_t w, input string tag);
      int lat  = 0;
      bit seen = 1'b0;
      while (lat < 200 && !seen) begin
         @(posedge clk);
         lat++;
         #1;
         if (out_valid) seen = 1'b1;
         else begin
            check({tag, "_sort_busy"}, 32'(busy), 32'd1);
            check({tag, "_sort_in_ready"}, 32'(in_ready), 32'd0);
         end
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_sort_cycles(w)));
   endtask

   task automatic drain_frame(input frame_t w, input int mode, input string tag);
      frame_t           e = model_sort(w);
      int               idx = 0;
      int               cyc = 0;
      logic [WIDTH-1:0] pd = '0;
      logic             pl = 1'b0;
      bit               prdy = 1'b1;
      while (idx < DEPTH && cyc < 200) begin
         bit rdy;
         @(negedge clk);
         check({tag, "_drain_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_drain_in_ready"}, 32'(in_ready), 32'd0);
         if (!prdy) begin
            check({tag, "_hold_data"}, 32'(out_data), 32'(pd));
            check({tag, "_hold_last"}, 32'(out_last), 32'(pl));
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3 == 0);
            default: rdy = 1'($urandom_range(1, 0));
         endcase
         out_ready = rdy;
         if (rdy) begin
            check({tag, "_data"}, 32'(out_data), 32'(e[idx]));
            check({tag, "_last"}, 32'(out_last), 32'(idx == DEPTH - 1));
            idx++;
         end
         pd   = out_data;
         pl   = out_last;
         prdy = rdy;
         cyc++;
      end
      check({tag, "_handshakes"}, 32'(idx), 32'(DEPTH));
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      check({tag, "_done_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_done_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic run_frame(input frame_t w, input int mode, input bit hold_aa, input string tag);
      load_frame(w, hold_aa);
      wait_sort(w, tag);
      drain_frame(w, mode, tag);
   endtask

   function automatic frame_t rand_frame(input bit narrow);
      frame_t r;
      for (int i = 0; i < DEPTH; i++)
         r[i] = narrow ? WIDTH'($urandom_range(3, 0)) : WIDTH'($urandom_range(255, 0));
      return r;
   endfunction

   initial begin
      frame_t f;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      f = '{8'd125, 8'd140, 8'd200, 8'd2, 8'd10, 8'd210, 8'd21, 8'd100};
      run_frame(f, 0, 1'b0, "t1");

      f = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
      run_frame(f, 0, 1'b0, "t2");

      f = '{8'd255, 8'd254, 8'd253, 8'd252, 8'd251, 8'd250, 8'd249, 8'd248};
      run_frame(f, 0, 1'b0, "t3");

      run_frame(rand_frame(1'b0), 1, 1'b0, "t4");

      // Reset ten cycles into a sort, then a fresh frame.
      f = rand_frame(1'b0);
      load_frame(f, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("t5_rst_out_valid", 32'(out_valid), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      f = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      run_frame(f, 0, 1'b0, "t5");

      run_frame(rand_frame(1'b0), 0, 1'b1, "t6");
      run_frame(rand_frame(1'b1), 2, 1'b0, "t6_next");

      for (int n = 0; n < 10; n++)
         run_frame(rand_frame(1'($urandom_range(1, 0))), int'($urandom_range(2, 0)),
                   1'($urandom_range(1, 0)), "rnd");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
